// File: rtl/rs_syndrome_gen.sv
// Reed-Solomon syndrome generator over GF(2^8), p(x) = 0x11D, alpha = 0x02, t = 3.
// Received symbols arrive highest degree first. S1..S6 = r(alpha^j) are accumulated
// by Horner's rule. They are published on w1..w6 with a one-cycle signal pulse.
module rs_syndrome_gen #(
    parameter int unsigned N = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_sym,
    output logic       in_ready,
    output logic [7:0] w1,
    output logic [7:0] w2,
    output logic [7:0] w3,
    output logic [7:0] w4,
    output logic [7:0] w5,
    output logic [7:0] w6,
    output logic       signal,
    output logic       err_flag,
    output logic       busy
);

    localparam logic [7:0] LAST_CNT = 8'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t     state_q;
    logic [7:0] acc_q [6];
    logic [7:0] count_q;
    logic [7:0] w_q [6];
    logic       signal_q;
    logic       err_q;
    logic       busy_q;
    logic       ready_q;

    logic [7:0] horner_d [6];
    logic       accept;
    logic       any_nz;

    // Multiply by alpha^p: p successive xtime steps with reduction by 0x11D
    function automatic logic [7:0] mul_alpha_pow(input logic [7:0] x, input int unsigned p);
        logic [7:0] r;
        r = x;
        for (int unsigned k = 0; k < p; k++) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h1D) : {r[6:0], 1'b0};
        end
        return r;
    endfunction

    assign accept = in_valid & ready_q;

    // Horner step for each syndrome: acc_j * alpha^j + r_k
    always_comb begin
        for (int unsigned j = 0; j < 6; j++) begin
            horner_d[j] = mul_alpha_pow(acc_q[j], j + 1) ^ in_sym;
        end
    end

    // Nonzero-syndrome detect over the final accumulators
    always_comb begin
        any_nz = 1'b0;
        for (int unsigned j = 0; j < 6; j++) begin
            any_nz = any_nz | (|acc_q[j]);
        end
    end

    // Frame FSM with registered handshake, status and syndrome outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            signal_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            for (int unsigned j = 0; j < 6; j++) begin
                acc_q[j] <= '0;
                w_q[j]   <= '0;
            end
        end else begin
            signal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        for (int unsigned j = 0; j < 6; j++) begin
                            acc_q[j] <= in_sym;
                        end
                        count_q <= 8'd1;
                        busy_q  <= 1'b1;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        for (int unsigned j = 0; j < 6; j++) begin
                            acc_q[j] <= horner_d[j];
                        end
                        count_q <= count_q + 8'd1;
                        if (count_q == LAST_CNT) begin
                            ready_q <= 1'b0;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    for (int unsigned j = 0; j < 6; j++) begin
                        w_q[j]   <= acc_q[j];
                        acc_q[j] <= '0;
                    end
                    err_q    <= any_nz;
                    signal_q <= 1'b1;
                    count_q  <= '0;
                    busy_q   <= 1'b0;
                    ready_q  <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready = ready_q;
    assign busy     = busy_q;
    assign signal   = signal_q;
    assign err_flag = err_q;
    assign w1       = w_q[0];
    assign w2       = w_q[1];
    assign w3       = w_q[2];
    assign w4       = w_q[3];
    assign w5       = w_q[4];
    assign w6       = w_q[5];

endmodule

// File: tb/tb_rs_syndrome_gen.sv
// Bench for rs_syndrome_gen. It drives an N=255 and an N=7 instance. The reference
// computes S_j = sum r_k * alpha^(j*k) directly from an antilog table, per accepted symbol.
module tb_rs_syndrome_gen;

    logic       clk;
    logic       rst_n;
    logic       valid  [2];
    logic [7:0] sym    [2];
    logic       rdy    [2];
    logic       sig    [2];
    logic       err_o  [2];
    logic       busy_o [2];
    logic [7:0] wo     [2][6];

    int compared;
    int mismatched;

    logic [7:0] alog [255];

    // reference model state
    int unsigned n_acc   [2];
    logic [7:0]  ssum    [2][6];
    logic [7:0]  pend    [2][6];
    logic        done_p  [2];
    logic        exp_sig [2];
    logic        exp_rdy [2];
    logic        exp_busy[2];
    logic        exp_err [2];
    logic [7:0]  exp_w   [2][6];

    rs_syndrome_gen #(.N(255)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(valid[0]), .in_sym(sym[0]),
        .in_ready(rdy[0]),
        .w1(wo[0][0]), .w2(wo[0][1]), .w3(wo[0][2]),
        .w4(wo[0][3]), .w5(wo[0][4]), .w6(wo[0][5]),
        .signal(sig[0]), .err_flag(err_o[0]), .busy(busy_o[0])
    );

    rs_syndrome_gen #(.N(7)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(valid[1]), .in_sym(sym[1]),
        .in_ready(rdy[1]),
        .w1(wo[1][0]), .w2(wo[1][1]), .w3(wo[1][2]),
        .w4(wo[1][3]), .w5(wo[1][4]), .w6(wo[1][5]),
        .signal(sig[1]), .err_flag(err_o[1]), .busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input int d, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s dut%0d[%0d] at %0t: got %0h expected %0h", nm, d, idx, $time, act, exp);
        end
    endtask

    // Reference model: tracks accepted symbols and what each output must be next cycle
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int unsigned nn;
            int unsigned deg;
            logic        acc;
            nn = (d == 0) ? 255 : 7;
            if (!rst_n) begin
                n_acc[d] = 0; done_p[d] = 1'b0; exp_sig[d] = 1'b0; exp_rdy[d] = 1'b1;
                exp_busy[d] = 1'b0; exp_err[d] = 1'b0;
                for (int j = 0; j < 6; j++) begin
                    ssum[d][j] = 8'h00; exp_w[d][j] = 8'h00;
                end
            end else begin
                acc = valid[d] && exp_rdy[d];
                exp_sig[d] = done_p[d];
                if (done_p[d]) begin
                    exp_err[d] = 1'b0;
                    for (int j = 0; j < 6; j++) begin
                        exp_w[d][j] = pend[d][j];
                        if (pend[d][j] != 8'h00) exp_err[d] = 1'b1;
                    end
                    done_p[d] = 1'b0;
                end
                if (acc) begin
                    deg = nn - 1 - n_acc[d];
                    for (int j = 0; j < 6; j++) begin
                        ssum[d][j] = ssum[d][j] ^ gf_mul(sym[d], alog[((j + 1) * deg) % 255]);
                    end
                    n_acc[d]++;
                    if (n_acc[d] == nn) begin
                        for (int j = 0; j < 6; j++) begin
                            pend[d][j] = ssum[d][j];
                            ssum[d][j] = 8'h00;
                        end
                        n_acc[d] = 0;
                        done_p[d] = 1'b1;
                    end
                end
                exp_rdy[d]  = !done_p[d];
                exp_busy[d] = done_p[d] || (n_acc[d] > 0);
            end
        end
    end

    // Compare process: every output of both instances, every cycle, on the falling edge
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("signal", d, 0, 32'(sig[d]), 32'(exp_sig[d]));
                chk("in_ready", d, 0, 32'(rdy[d]), 32'(exp_rdy[d]));
                chk("busy", d, 0, 32'(busy_o[d]), 32'(exp_busy[d]));
                chk("err_flag", d, 0, 32'(err_o[d]), 32'(exp_err[d]));
                for (int j = 0; j < 6; j++) begin
                    chk("w", d, j + 1, 32'(wo[d][j]), 32'(exp_w[d][j]));
                end
            end
        end
    end

    task automatic send_sym(input int d, input logic [7:0] s);
        int guard;
        guard = 0;
        valid[d] = 1'b1;
        sym[d]   = s;
        while (!rdy[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy[d]) chk("ready_timeout", d, 0, 32'(rdy[d]), 32'd1);
        @(negedge clk);
    endtask

    task automatic idle(input int d, input int n);
        valid[d] = 1'b0;
        sym[d]   = 8'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sig(input int d);
        int guard;
        guard = 0;
        while (!sig[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("signal_wait", d, 0, 32'(sig[d]), 32'd1);
    endtask

    task automatic lit_check(input string nm, input logic [7:0] e [6], input logic ef);
        for (int j = 0; j < 6; j++) chk(nm, 0, j + 1, 32'(wo[0][j]), 32'(e[j]));
        chk({nm, "_err"}, 0, 0, 32'(err_o[0]), 32'(ef));
    endtask

    initial begin
        logic [7:0] zeros [6];
        logic [7:0] fives [6];
        logic [7:0] inv   [6];
        logic [7:0] a;
        compared   = 0;
        mismatched = 0;
        zeros = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        fives = '{8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05};
        inv   = '{8'h8E, 8'h47, 8'hAD, 8'hD8, 8'h6C, 8'h36};

        a = 8'h01;
        for (int i = 0; i < 255; i++) begin
            alog[i] = a;
            a = gf_mul(a, 8'h02);
        end
        chk("alog1", 0, 1, 32'(alog[1]), 32'h02);
        chk("alog8", 0, 8, 32'(alog[8]), 32'h1D);
        chk("alog254", 0, 254, 32'(alog[254]), 32'h8E);

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            valid[d] = 1'b0;
            sym[d]   = 8'h00;
        end
        repeat (3) @(negedge clk);
        lit_check("reset", zeros, 1'b0);
        rst_n = 1'b1;

        // all-zero frame
        for (int i = 0; i < 255; i++) send_sym(0, 8'h00);
        valid[0] = 1'b0;
        wait_sig(0);
        lit_check("zero_frame", zeros, 1'b0);

        // only r_0 = 0x05
        for (int i = 0; i < 255; i++) send_sym(0, (i == 254) ? 8'h05 : 8'h00);
        valid[0] = 1'b0;
        wait_sig(0);
        lit_check("r0_only", fives, 1'b1);

        // only r_254 = 0x01
        for (int i = 0; i < 255; i++) send_sym(0, (i == 0) ? 8'h01 : 8'h00);
        valid[0] = 1'b0;
        wait_sig(0);
        lit_check("r254_only", inv, 1'b1);

        // same frame with random idle gaps
        for (int i = 0; i < 255; i++) begin
            if ($urandom_range(0, 9) < 3) idle(0, int'($urandom_range(1, 2)));
            send_sym(0, (i == 0) ? 8'h01 : 8'h00);
        end
        valid[0] = 1'b0;
        wait_sig(0);
        lit_check("r254_gaps", inv, 1'b1);

        // reset mid-frame, then a clean all-zero frame
        for (int i = 0; i < 100; i++) send_sym(0, 8'($urandom));
        valid[0] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lit_check("after_reset", zeros, 1'b0);
        for (int i = 0; i < 255; i++) send_sym(0, 8'h00);
        valid[0] = 1'b0;
        wait_sig(0);
        lit_check("post_reset_frame", zeros, 1'b0);

        // back-to-back random frames, valid held high
        for (int i = 0; i < 2 * 255; i++) send_sym(0, 8'($urandom));
        valid[0] = 1'b0;
        wait_sig(0);
        for (int i = 0; i < 3 * 7; i++) send_sym(1, 8'($urandom));
        valid[1] = 1'b0;
        wait_sig(1);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
